// File: rtl/ram1_blit_feeder.sv
// Buffers compute result words in a FIFO and issues them to the ram1 blit stage with incrementing addresses.
// Optional build macro RAM1_BLIT_FEEDER_STATS_EN enables the stall_cycles statistics counter.
module ram1_blit_feeder #(
   parameter int COMPUTE_OUT_FULL_WIDTH = 64,
   parameter int BLIT_ADDR_WIDTH        = 16,
   parameter int FIFO_DEPTH_LOG2        = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [BLIT_ADDR_WIDTH-1:0]        base_addr,
   input  logic [BLIT_ADDR_WIDTH-1:0]        word_count,
   output logic                              busy,
   output logic                              done,
   input  logic                              in_valid,
   input  logic [COMPUTE_OUT_FULL_WIDTH-1:0] in_data,
   output logic                              in_ready,
   output logic                              blit_req,
   output logic [COMPUTE_OUT_FULL_WIDTH-1:0] blit_data,
   output logic [BLIT_ADDR_WIDTH-1:0]        blit_addr,
   input  logic                              blit_ready,
   output logic [31:0]                       stall_cycles
);

   localparam logic [FIFO_DEPTH_LOG2:0] FIFO_DEPTH = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                            state;
   logic [COMPUTE_OUT_FULL_WIDTH-1:0] fifo_mem [1 << FIFO_DEPTH_LOG2];
   logic [FIFO_DEPTH_LOG2-1:0]        wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0]        rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]          fifo_cnt;
   logic [BLIT_ADDR_WIDTH-1:0]        frame_count;
   logic [BLIT_ADDR_WIDTH-1:0]        accepted;
   logic [BLIT_ADDR_WIDTH-1:0]        issued;
   logic [BLIT_ADDR_WIDTH-1:0]        next_addr;
   logic                              fifo_full;
   logic                              fifo_nonempty;
   logic                              push;
   logic                              pop;

   assign fifo_full     = (fifo_cnt == FIFO_DEPTH);
   assign fifo_nonempty = (fifo_cnt != '0);
   assign in_ready      = (state == RUN) && !fifo_full && (accepted < frame_count);
   assign push          = in_valid && in_ready;
   // blit_req doubles as the holdoff: the blit stage's ready is stale in the cycle it sees req
   assign pop           = (state == RUN) && fifo_nonempty && blit_ready && !blit_req;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         frame_count <= '0;
         accepted    <= '0;
         issued      <= '0;
         next_addr   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         blit_req    <= 1'b0;
         blit_data   <= '0;
         blit_addr   <= '0;
      end else begin
         done     <= 1'b0;
         blit_req <= 1'b0;

         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            accepted <= accepted + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            blit_data <= fifo_mem[rd_ptr];
            blit_addr <= next_addr;
            next_addr <= next_addr + 1'b1;
            issued    <= issued + 1'b1;
            blit_req  <= 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase

         case (state)
            IDLE: begin
               if (start) begin
                  frame_count <= word_count;
                  next_addr   <= base_addr;
                  accepted    <= '0;
                  issued      <= '0;
                  if (word_count == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               // every accepted word has been popped, so the FIFO is already empty here
               if (issued == frame_count) state <= DRAIN;
            end
            DRAIN: begin
               if (blit_ready && !blit_req) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RAM1_BLIT_FEEDER_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (state == IDLE && start) begin
         stall_q <= '0;
      end else if ((state == RUN || state == DRAIN) && fifo_nonempty &&
                   (!blit_ready || blit_req) && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ram1_blit_feeder.sv
// Directed bench for ram1_blit_feeder: ordering, address wrap, empty frame, backpressure, reset, stall stats.
module tb_ram1_blit_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        blit_req;
   logic [63:0] blit_data;
   logic [15:0] blit_addr;
   logic        blit_ready;
   logic [31:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   logic [15:0] rq_addr[$];
   logic [63:0] rq_data[$];
   int          done_cnt = 0;
   int          rdy_cnt  = 0;

   ram1_blit_feeder dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .blit_req(blit_req), .blit_data(blit_data), .blit_addr(blit_addr),
      .blit_ready(blit_ready), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (blit_req) begin
         rq_addr.push_back(blit_addr);
         rq_data.push_back(blit_data);
      end
      if (done) done_cnt++;
      if (in_ready) rdy_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wd(input int t, input int i);
      return {32'hD0D0_0000 | 32'(t), 32'(i) ^ 32'h5A5A_0000};
   endfunction

   task automatic do_start(input logic [15:0] b, input logic [15:0] c);
      start = 1'b1; base_addr = b; word_count = c;
      step();
      start = 1'b0;
   endtask

   task automatic push_word(input logic [63:0] d);
      int n = 0;
      in_valid = 1'b1; in_data = d;
      while (!in_ready && n < 300) begin step(); n++; end
      if (n >= 300) chk("push_timeout", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 500) begin step(); n++; end
      repeat (4) step();
      chk("done_once", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int q0, d0, r0;
      rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      in_valid = 1'b0; in_data = '0; blit_ready = 1'b1;
      repeat (3) step();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_req", {63'd0, blit_req}, 64'd0);
      chk("rst_data", blit_data, 64'd0);
      chk("rst_addr", {48'd0, blit_addr}, 64'd0);
      chk("rst_stall", {32'd0, stall_cycles}, 64'd0);
      rst = 1'b0;
      step();

      // 1: basic frame of four words
      q0 = rq_addr.size(); d0 = done_cnt;
      do_start(16'h0100, 16'd4);
      chk("t1_busy", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 4; i++) push_word(wd(1, i));
      wait_done(d0);
      chk("t1_nreq", 64'(rq_addr.size() - q0), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", {48'd0, rq_addr[q0+i]}, 64'h0100 + 64'(i));
         chk("t1_data", rq_data[q0+i], wd(1, i));
      end
      chk("t1_busy_end", {63'd0, busy}, 64'd0);

      // 2: address wrap
      q0 = rq_addr.size(); d0 = done_cnt;
      do_start(16'hFFFE, 16'd4);
      for (int i = 0; i < 4; i++) push_word(wd(2, i));
      wait_done(d0);
      chk("t2_nreq", 64'(rq_addr.size() - q0), 64'd4);
      chk("t2_addr0", {48'd0, rq_addr[q0]},   64'hFFFE);
      chk("t2_addr1", {48'd0, rq_addr[q0+1]}, 64'hFFFF);
      chk("t2_addr2", {48'd0, rq_addr[q0+2]}, 64'h0000);
      chk("t2_addr3", {48'd0, rq_addr[q0+3]}, 64'h0001);

      // 3: empty frame
      q0 = rq_addr.size(); d0 = done_cnt; r0 = rdy_cnt;
      do_start(16'h0040, 16'd0);
      chk("t3_done_c1", {63'd0, done}, 64'd0);
      chk("t3_busy", {63'd0, busy}, 64'd0);
      step();
      chk("t3_done_c2", {63'd0, done}, 64'd1);
      step();
      chk("t3_done_c3", {63'd0, done}, 64'd0);
      step();
      chk("t3_nreq", 64'(rq_addr.size() - q0), 64'd0);
      chk("t3_ready_cnt", 64'(rdy_cnt - r0), 64'd0);
      chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

      // 4: backpressure fills the FIFO
      q0 = rq_addr.size(); d0 = done_cnt;
      blit_ready = 1'b0;
      do_start(16'h0200, 16'd20);
      for (int i = 0; i < 16; i++) push_word(wd(4, i));
      in_valid = 1'b1; in_data = wd(4, 16);
      repeat (3) step();
      chk("t4_full_ready", {63'd0, in_ready}, 64'd0);
      chk("t4_no_req", 64'(rq_addr.size() - q0), 64'd0);
      blit_ready = 1'b1;
      for (int i = 16; i < 20; i++) push_word(wd(4, i));
      wait_done(d0);
      chk("t4_nreq", 64'(rq_addr.size() - q0), 64'd20);
      for (int i = 0; i < 20; i++) begin
         chk("t4_data", rq_data[q0+i], wd(4, i));
         chk("t4_addr", {48'd0, rq_addr[q0+i]}, 64'h0200 + 64'(i));
      end

      // 5: reset mid-frame, then a fresh frame
      q0 = rq_addr.size(); d0 = done_cnt;
      do_start(16'h0500, 16'd8);
      for (int i = 0; i < 8 && (rq_addr.size() - q0) < 3; i++) push_word(wd(5, i));
      while ((rq_addr.size() - q0) < 3) step();
      rst = 1'b1;
      #1;
      chk("t5_busy", {63'd0, busy}, 64'd0);
      chk("t5_req", {63'd0, blit_req}, 64'd0);
      chk("t5_addr", {48'd0, blit_addr}, 64'd0);
      chk("t5_data", blit_data, 64'd0);
      chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
      q0 = rq_addr.size(); d0 = done_cnt;
      do_start(16'h0300, 16'd2);
      push_word(wd(6, 0));
      push_word(wd(6, 1));
      wait_done(d0);
      chk("t5_nreq", 64'(rq_addr.size() - q0), 64'd2);
      chk("t5_addr0", {48'd0, rq_addr[q0]}, 64'h0300);
      chk("t5_addr1", {48'd0, rq_addr[q0+1]}, 64'h0301);
      chk("t5_data1", rq_data[q0+1], wd(6, 1));

      // 6: stall statistics
      d0 = done_cnt;
      blit_ready = 1'b0;
      do_start(16'h0000, 16'd1);
      push_word(wd(7, 0));
      repeat (10) step();
      blit_ready = 1'b1;
      wait_done(d0);
`ifdef RAM1_BLIT_FEEDER_STATS_EN
      chk("t6_stall", {32'd0, stall_cycles}, 64'd10);
`else
      chk("t6_stall", {32'd0, stall_cycles}, 64'd0);
`endif
      do_start(16'h0000, 16'd0);
      chk("t6_stall_clr", {32'd0, stall_cycles}, 64'd0);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
